// File: rtl/sr_chk_pkg.sv
// Shared types and constants for the SR flip-flop response checker.
// Holds the model state encoding and the {S,R} input codes.
// Optional sticky fail flag in the top is enabled with SR_CHECK_STICKY_EN.
package sr_chk_pkg;

  // Model confidence state. Encoding 3 is unused and decodes to UNK.
  typedef enum logic [1:0] {
    ST_UNK   = 2'd0,
    ST_TRACK = 2'd1,
    ST_ILL   = 2'd2
  } sr_state_e;

  // Input codes, ordered {S,R}.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

  // Collapse the unused encoding onto UNK so a corrupted state register
  // falls back to "not known" instead of producing bogus checks.
  function automatic sr_state_e sr_state_decode(input sr_state_e st);
    sr_state_e res;
    case (st)
      ST_TRACK: res = ST_TRACK;
      ST_ILL:   res = ST_ILL;
      default:  res = ST_UNK;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_ff_model.sv
// Combinational golden next-state of an SR flip-flop plus model confidence.
// Zero latency; purely combinational, no flow control.
// Produces next expected Q, next state and the illegal-input flag.
module sr_ff_model
  import sr_chk_pkg::*;
(
  input  logic      s_i,
  input  logic      r_i,
  input  logic      exp_q_i,
  input  sr_state_e state_i,
  output logic      next_exp_q_o,
  output sr_state_e next_state_o,
  output logic      illegal_o
);

  sr_state_e state_dec;

  assign state_dec = sr_state_decode(state_i);

  // Next model value: set/reset force a known value, hold keeps everything,
  // S=R=1 leaves the old value in place but marks the model as undefined.
  always_comb begin
    next_exp_q_o = exp_q_i;
    next_state_o = state_dec;
    illegal_o    = 1'b0;
    case ({s_i, r_i})
      SR_SET: begin
        next_exp_q_o = 1'b1;
        next_state_o = ST_TRACK;
      end
      SR_RST: begin
        next_exp_q_o = 1'b0;
        next_state_o = ST_TRACK;
      end
      SR_ILL: begin
        next_state_o = ST_ILL;
        illegal_o    = 1'b1;
      end
      default: begin
        next_exp_q_o = exp_q_i;
        next_state_o = state_dec;
      end
    endcase
  end

endmodule

// File: rtl/sr_ff_checker.sv
// Response monitor for a clocked SR flip-flop: golden model, per-cycle compare, counters.
// A bad DUT update at edge k is flagged (MISMATCH, ERR_CNT) at edge k+1; all outputs registered.
// No backpressure; samples every edge. SR_CHECK_STICKY_EN adds the sticky FAIL output.
module sr_ff_checker
  import sr_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  output logic             EXP_Q,
  output logic             VALID,
  output logic             MISMATCH,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT
`ifdef SR_CHECK_STICKY_EN
  ,
  output logic             FAIL
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sr_state_e        state_q, state_d;
  logic             exp_q_q, exp_q_d;
  logic             valid_q;
  logic             mismatch_q, mismatch_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             cmp_en;

  sr_ff_model u_model (
    .s_i          (S),
    .r_i          (R),
    .exp_q_i      (exp_q_q),
    .state_i      (state_q),
    .next_exp_q_o (exp_q_d),
    .next_state_o (state_d),
    .illegal_o    (illegal_d)
  );

  // A compare happens on this edge only if the model was known after the
  // previous edge; it always uses the old EXP_Q, before the model updates.
  // Case inequality makes an X/Z on Q count as a mismatch.
  always_comb begin
    cmp_en     = (state_q == ST_TRACK);
    mismatch_d = cmp_en && (Q !== exp_q_q);
    chk_cnt_d  = chk_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cmp_en && (chk_cnt_q != CNT_MAX)) begin
      chk_cnt_d = chk_cnt_q + CNT_ONE;
    end
    // Error counting is independent of the check counter saturating.
    if (mismatch_d && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  // Golden model registers; reset wins over any S/R on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_UNK;
      exp_q_q   <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q_q   <= exp_q_d;
      valid_q   <= (state_d == ST_TRACK);
      illegal_q <= illegal_d;
    end
  end

  // Compare result pulse and saturating check/error counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mismatch_q <= 1'b0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef SR_CHECK_STICKY_EN
  logic fail_q;

  // Sticky fail: rises on the same edge as the first mismatch pulse, held until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fail_q <= 1'b0;
    end else begin
      fail_q <= fail_q | mismatch_d;
    end
  end

  assign FAIL = fail_q;
`endif

  assign EXP_Q    = exp_q_q;
  assign VALID    = valid_q;
  assign MISMATCH = mismatch_q;
  assign ILLEGAL  = illegal_q;
  assign CHK_CNT  = chk_cnt_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
